// File: rtl/i2s_dac_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// i2s_dac_transmitter_pkg
// Shared audio-path constants used by the I2S DAC transmitter.
//
// Contents:
//   SAMPLE_WIDTH - bits per channel word on the audio path (24-bit samples).
// -----------------------------------------------------------------------------
package i2s_dac_transmitter_pkg;

    // Word width of every sample on the audio path; one stereo frame carries
    // two of these words, so the bit clock runs 2*SAMPLE_WIDTH per frame.
    localparam int SAMPLE_WIDTH = 24;

endpackage

// File: rtl/i2s_dac_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_dac_transmitter
// Serialises one stereo sample pair per frame into a standard I2S stream for
// the external audio DAC. The frame is 2*WIDTH bit clocks long. lrclk is low
// for the left half and high for the right half. Data lags the lrclk
// transition by one bit clock and is sent MSB first.
//
// Parameters:
//   WIDTH       - bits per channel word (defaults to SAMPLE_WIDTH)
//
// Ports:
//   clk         - in  : bit clock, also forwarded to the DAC as serial clock
//   rst_n       - in  : synchronous active-low reset
//   enable      - in  : run/idle, behaves like a synchronous clear when low
//   left_data   - in  : signed left sample, captured once per frame
//   right_data  - in  : signed right sample, captured once per frame
//   lrclk       - out : word select, 0 = left, 1 = right
//   sd          - out : serial data, MSB first
// -----------------------------------------------------------------------------
module i2s_dac_transmitter
    import i2s_dac_transmitter_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] left_data,
    input  logic [WIDTH-1:0] right_data,
    output logic             lrclk,
    output logic             sd
);

    localparam int                 FRAME_LEN = 2 * WIDTH;
    localparam int                 CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]   HALF      = CNT_W'(WIDTH);

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [WIDTH-1:0]     left_shadow;
    logic [WIDTH-1:0]     right_shadow;
    logic                 capture;
    logic [FRAME_LEN-1:0] frame_bits;
    logic [CNT_W-1:0]     bit_pos;
    logic                 lrclk_next;
    logic                 sd_next;

    // Next-state logic for the frame position and the bit to present there.
    // The outputs are registered, so everything is computed for the cycle
    // the counter is about to enter (cnt_next). The left and right words are
    // viewed as one 2*WIDTH vector {L, R}. Cycle c then carries bit 2*WIDTH-c,
    // which gives L[MSB] at c=1, L[0] at c=WIDTH and R[1] at c=2*WIDTH-1.
    // Cycle 0 wraps around to R[0], the right LSB of the previous pair.
    // On the capture edge (cnt 0 -> 1) the shadows are not loaded yet, so
    // the live inputs feed the mux directly to get the left MSB out at c=1.
    always_comb begin
        cnt_next   = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        capture    = (cnt == '0);
        frame_bits = capture ? {left_data, right_data}
                             : {left_shadow, right_shadow};
        bit_pos    = (cnt_next == '0) ? '0 : (CNT_LAST - cnt_next) + CNT_W'(1);
        sd_next    = frame_bits[bit_pos];
        lrclk_next = (cnt_next >= HALF);
    end

    // Frame state. It is clocked on the falling edge of the bit clock so that
    // sd and lrclk have half a period to settle before the DAC samples them on
    // the rising edge. Reset and a low enable both return the block to the
    // cleared frame-start state, so a re-enabled stream always begins at cnt=0
    // with a zero c=0 bit. The shadows load only on the 0 -> 1 edge, so input
    // changes mid-frame never tear the pair being sent.
    always_ff @(negedge clk) begin
        if (!rst_n || !enable) begin
            cnt          <= '0;
            lrclk        <= 1'b0;
            sd           <= 1'b0;
            left_shadow  <= '0;
            right_shadow <= '0;
        end else begin
            cnt   <= cnt_next;
            lrclk <= lrclk_next;
            sd    <= sd_next;
            if (capture) begin
                left_shadow  <= left_data;
                right_shadow <= right_data;
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_dac_transmitter
// Bench for i2s_dac_transmitter. Stimulus drives sample pairs frame by frame
// and queues the pairs it expects on the wire. An independent monitor decodes
// the I2S stream at the DAC sample point (rising edge), checks lrclk against
// its own frame-position model, and compares each recovered pair with the
// queue.
// -----------------------------------------------------------------------------
module tb_i2s_dac_transmitter;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [W-1:0] left_data;
    logic [W-1:0] right_data;
    logic         lrclk;
    logic         sd;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2*W-1:0] exp_q[$];

    bit           ctl_active = 1'b0;
    bit           monitor_on = 1'b0;
    int           c_model    = 0;
    logic         prev_lr    = 1'b0;
    logic [W-1:0] word       = '0;
    logic [W-1:0] left_word  = '0;
    int           nbits      = 0;
    bit           have_left  = 1'b0;
    int           pair_idx   = 0;

    i2s_dac_transmitter #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .left_data (left_data),
        .right_data(right_data),
        .lrclk     (lrclk),
        .sd        (sd)
    );

    // Bit clock: 10 time units per period, falling edge is the DUT's active edge.
    always #5 clk = ~clk;

    // Single comparison point; every check goes through here so the counters
    // in the summary line are the ones that record each result.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one full frame. Entry point is just after the rising edge of a
    // c=0 cycle, so the next falling edge captures the pair. Optionally the
    // inputs are changed tear_at cycles into the frame to show they are not
    // picked up until the following frame.
    task automatic applyStimulus(input logic [W-1:0] l, input logic [W-1:0] r,
                                 input int tear_at, input logic [W-1:0] tear_l);
        left_data  = l;
        right_data = r;
        exp_q.push_back({l, r});
        if (tear_at > 0) begin
            repeat (tear_at) @(posedge clk);
            #1;
            left_data  = tear_l;
            right_data = ~r;
            repeat (2*W - tear_at) @(posedge clk);
        end else begin
            repeat (2*W) @(posedge clk);
        end
        #1;
    endtask

    // Start a frame, drop enable at c=30 for three clocks and restore it.
    // The aborted pair is never expected on the wire.
    task automatic dropEnable();
        left_data  = 24'h123456;
        right_data = 24'h654321;
        repeat (30) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (3) begin
            @(posedge clk);
            checkOutput("disabled_lrclk", 64'(lrclk), 64'(0));
            checkOutput("disabled_sd",    64'(sd),    64'(0));
        end
        #1;
        enable = 1'b1;
    endtask

    // Record whether the DUT saw an active (running) falling edge, using the
    // same control values the DUT samples on that edge.
    always @(negedge clk) begin
        ctl_active = rst_n && enable;
        monitor_on = 1'b1;
    end

    // I2S monitor. While idle the outputs must sit at zero and the decoder is
    // cleared. While running, a frame-position model predicts lrclk, and each
    // sd bit is shifted into the word of the channel selected one bit clock
    // earlier; an lrclk change marks the LSB of that word. A completed right
    // word closes a pair, which is compared against the scoreboard queue.
    always @(posedge clk) begin
        logic [2*W-1:0] exp_pair;
        logic           exp_lr;
        if (monitor_on) begin
            if (!ctl_active) begin
                checkOutput("idle_lrclk", 64'(lrclk), 64'(0));
                checkOutput("idle_sd",    64'(sd),    64'(0));
                c_model   = 0;
                prev_lr   = 1'b0;
                word      = '0;
                nbits     = 0;
                have_left = 1'b0;
            end else begin
                c_model = (c_model + 1) % (2*W);
                exp_lr  = (c_model >= W);
                checkOutput($sformatf("lrclk_c%0d", c_model), 64'(lrclk), 64'(exp_lr));
                word  = {word[W-2:0], sd};
                nbits = nbits + 1;
                if (lrclk != prev_lr) begin
                    checkOutput("word_len", 64'(nbits), 64'(W));
                    if (prev_lr == 1'b0) begin
                        left_word = word;
                        have_left = 1'b1;
                    end else begin
                        checkOutput("pair_has_left", 64'(have_left), 64'(1));
                        if (exp_q.size() == 0) begin
                            tests_run++;
                            tests_failed++;
                            $display("[TB] FAIL unexpected_pair: got L=%h R=%h, expected none",
                                     left_word, word);
                        end else begin
                            exp_pair = exp_q.pop_front();
                            checkOutput($sformatf("pair%0d_left", pair_idx),
                                        64'(left_word), 64'(exp_pair[2*W-1:W]));
                            checkOutput($sformatf("pair%0d_right", pair_idx),
                                        64'(word), 64'(exp_pair[W-1:0]));
                        end
                        pair_idx++;
                        have_left = 1'b0;
                    end
                    word  = '0;
                    nbits = 0;
                end
                prev_lr = lrclk;
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog timeout");
    end

    // Directed sequence: reset, basic pair, extremes, no-tearing, enable drop,
    // then 100 back-to-back frames of incrementing samples.
    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        left_data  = '0;
        right_data = '0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(24'hA5A5A5, 24'h3C3C3C, 0, '0);
        applyStimulus(24'h800000, 24'h7FFFFF, 0, '0);
        applyStimulus(24'h000000, 24'h5A5A5A, 5, 24'hFFFFFF);
        applyStimulus(24'hFFFFFF, 24'h123456, 0, '0);
        dropEnable();
        applyStimulus(24'h654321, 24'hFEDCBA, 0, '0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(W'(24'h000100 + i), W'(24'h7FFFC0 + i), 0, '0);
        end

        repeat (2) @(posedge clk);
        checkOutput("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
